// File: rtl/microwave_pkg.sv
// microwave_pkg: shared state encoding, power-mode constants and duty table for the cook controller.
package microwave_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SET   = 3'd1,
        ST_COOK  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [1:0] MODE_FULL    = 2'b00;
    localparam logic [1:0] MODE_HIGH    = 2'b01;
    localparam logic [1:0] MODE_MED     = 2'b10;
    localparam logic [1:0] MODE_DEFROST = 2'b11;

    // magnetron-on ticks per duty window, indexed by power mode
    localparam int ON_TICKS [4] = '{10, 7, 5, 3};

    function automatic int on_ticks(logic [1:0] m);
        return ON_TICKS[m];
    endfunction

    function automatic int sat_add(int v, int a, int m);
        return (v + a > m) ? m : v + a;
    endfunction

endpackage

// File: rtl/cook_sequencer_if.sv
// cook_sequencer_if: user-event inputs and cook status outputs of the cook controller.
interface cook_sequencer_if #(
    parameter int SEC_W = 13
);
    logic             start;
    logic             cancel;
    logic             add_time;
    logic             door_open;
    logic [1:0]       mode;
    logic [SEC_W-1:0] remaining;
    logic [2:0]       state_o;
    logic             magnetron_en;
    logic             cook_active;
    logic             idle;
    logic             timer_end;
    logic             beep;
    logic             mini_rst;

    modport master (
        output start, cancel, add_time, door_open, mode,
        input  remaining, state_o, magnetron_en, cook_active, idle, timer_end, beep, mini_rst
    );

    modport slave (
        input  start, cancel, add_time, door_open, mode,
        output remaining, state_o, magnetron_en, cook_active, idle, timer_end, beep, mini_rst
    );
endinterface

// File: rtl/cook_sequencer_sec_tick_gen.sv
// sec_tick_gen: 1-second prescaler; held at zero while disabled so every enable starts a full period.
module sec_tick_gen #(
    parameter int DIV = 100_000_000
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int CW = DIV > 1 ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = en && cnt == CW'(DIV - 1);

    always_ff @(posedge sys_clk)
        if (!sys_rst || clr) cnt <= '0;
        else if (en) cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/cook_sequencer.sv
// cook_sequencer: cook-cycle FSM owning the seconds countdown, magnetron duty pattern and end beep.
module cook_sequencer
    import microwave_pkg::*;
#(
    parameter int TICK_DIV   = 100_000_000,
    parameter int ADD_SEC    = 30,
    parameter int MAX_SEC    = 5999,
    parameter int SEC_W      = 13,
    parameter int DUTY_LEN   = 10,
    parameter int BEEP_TICKS = 3
) (
    input logic             sys_clk,
    input logic             sys_rst,
    cook_sequencer_if.slave bus
);
    localparam int DW = $clog2(DUTY_LEN);
    localparam int BW = $clog2(BEEP_TICKS + 1);

    state_t           state, nxt;
    logic [SEC_W-1:0] remaining, rem_n, plus;
    logic [DW-1:0]    duty, duty_n;
    logic [BW-1:0]    beep_cnt;
    logic [1:0]       mode_l;
    logic             run, tick, dec, latch, go_cook;
    logic             cook_active, idle, timer_end, beep, mini_rst;

    assign run     = state == ST_COOK || state == ST_DONE;
    assign dec     = state == ST_COOK && tick;
    assign go_cook = bus.start && !bus.door_open;
    // an add_time landing on a tick adds on top of the decremented value
    assign plus    = SEC_W'(sat_add(int'(remaining) - int'(dec), ADD_SEC, MAX_SEC));

    sec_tick_gen #(.DIV(TICK_DIV)) u_tick (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .en      (run),
        .clr     (!run),
        .tick    (tick)
    );

    always_comb begin
        nxt    = state;
        rem_n  = remaining;
        duty_n = duty;
        latch  = 1'b0;
        case (state)
            ST_IDLE:
                if (!bus.cancel && go_cook) begin
                    nxt    = ST_COOK;
                    rem_n  = plus;
                    duty_n = '0;
                    latch  = 1'b1;
                end else if (!bus.cancel && bus.add_time) begin
                    nxt   = ST_SET;
                    rem_n = plus;
                end
            ST_SET, ST_PAUSE:
                if (bus.cancel) begin
                    nxt   = ST_IDLE;
                    rem_n = '0;
                end else if (go_cook) begin
                    nxt    = ST_COOK;
                    duty_n = state == ST_SET ? '0 : duty;
                    latch  = 1'b1;
                end else if (bus.add_time) rem_n = plus;
            ST_COOK:
                if (bus.cancel || bus.door_open) nxt = ST_PAUSE;
                else begin
                    if (tick) duty_n = duty == DW'(DUTY_LEN - 1) ? '0 : duty + 1'b1;
                    if (bus.add_time) rem_n = plus;
                    else if (tick) begin
                        rem_n = remaining - 1'b1;
                        nxt   = remaining == SEC_W'(1) ? ST_DONE : ST_COOK;
                    end
                end
            ST_DONE:
                if (bus.cancel || bus.door_open || bus.start) nxt = ST_IDLE;
                else if (tick && beep_cnt == BW'(BEEP_TICKS - 1)) nxt = ST_IDLE;
            default: nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            state       <= ST_IDLE;
            remaining   <= '0;
            duty        <= '0;
            mode_l      <= MODE_FULL;
            beep_cnt    <= '0;
            cook_active <= 1'b0;
            idle        <= 1'b1;
            timer_end   <= 1'b0;
            beep        <= 1'b0;
            mini_rst    <= 1'b0;
        end else begin
            state       <= nxt;
            remaining   <= rem_n;
            duty        <= duty_n;
            mode_l      <= latch ? bus.mode : mode_l;
            beep_cnt    <= state != ST_DONE ? '0 : beep_cnt + BW'(tick);
            cook_active <= nxt == ST_COOK;
            idle        <= nxt == ST_IDLE;
            timer_end   <= state == ST_COOK && nxt == ST_DONE;
            beep        <= nxt == ST_DONE;
            mini_rst    <= nxt == ST_IDLE && state != ST_IDLE;
        end
    end

    // door gating is combinational so the magnetron drops in the cycle the door opens
    assign bus.magnetron_en = state == ST_COOK && !bus.door_open && int'(duty) < on_ticks(mode_l);
    assign bus.remaining    = remaining;
    assign bus.state_o      = state;
    assign bus.cook_active  = cook_active;
    assign bus.idle         = idle;
    assign bus.timer_end    = timer_end;
    assign bus.beep         = beep;
    assign bus.mini_rst     = mini_rst;
endmodule
